// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access stage of the five-stage pipeline. Sits between the EX/MEM
// pipeline register and the writeback mux. Issues at most one load or store
// per instruction to a variable-latency data memory over a req/ready
// handshake. It freezes the upstream stages with mem_stall while the access
// is outstanding, and it holds the MEM/WB pipeline register.
//
// Parameters
//   MAX_WAIT      WAIT-state cycles allowed before an access is abandoned
//                 (1..255).
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   MEM_MemWrite/MemRead  store / load request from EX/MEM (both => store)
//   MEM_MemtoReg          writeback source select (1 = memory data)
//   MEM_RegWrite          destination register write enable
//   MEM_ALUval            effective address (memory ops) or ALU result
//   MEM_ReadData2         store data
//   MEM_DstReg            destination register index
//   dmem_req              one-cycle request pulse (combinational, IDLE only)
//   dmem_wr/addr/wdata    access attributes, valid with dmem_req
//   dmem_rdata/ready      memory response, sampled only in WAIT
//   mem_stall             combinational freeze of PC, IF/ID, ID/EX, EX/MEM
//   mem_timeout           sticky flag: an access was abandoned
//   WB_*                  registered MEM/WB pipeline outputs
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MEM_MemWrite,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemtoReg,
  input  logic        MEM_RegWrite,
  input  logic [15:0] MEM_ALUval,
  input  logic [15:0] MEM_ReadData2,
  input  logic [3:0]  MEM_DstReg,
  output logic        dmem_req,
  output logic        dmem_wr,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        mem_stall,
  output logic        mem_timeout,
  output logic        WB_RegWrite,
  output logic        WB_MemtoReg,
  output logic [15:0] WB_ALUval,
  output logic [15:0] WB_MemData,
  output logic [3:0]  WB_DstReg
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  // Last WAIT cycle index; reaching it without ready abandons the access.
  localparam logic [7:0] C_LAST = 8'(MAX_WAIT - 32'd1);

  // Source of the next WB_MemData value.
  localparam logic [1:0] MD_HOLD  = 2'd0;
  localparam logic [1:0] MD_RDATA = 2'd1;
  localparam logic [1:0] MD_ZERO  = 2'd2;

  logic [0:0]  r_state;
  logic [7:0]  r_cnt;
  logic        r_wr;
  logic        r_timeout;
  logic        r_wb_regwrite;
  logic        r_wb_memtoreg;
  logic [15:0] r_wb_aluval;
  logic [15:0] r_wb_memdata;
  logic [3:0]  r_wb_dstreg;

  logic [0:0]  w_state_nxt;
  logic [7:0]  w_cnt_nxt;
  logic        w_wr_nxt;
  logic        w_timeout_nxt;
  logic        w_access;
  logic        w_req;
  logic        w_stall;
  logic        w_retire;
  logic [1:0]  w_md_sel;

  // Gating with rst_n keeps req/stall low while reset is held, even though
  // the frozen EX/MEM register may still present a memory instruction.
  assign w_access = rst_n & (MEM_MemRead | MEM_MemWrite);

  // Next-state, handshake and stall decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_wr_nxt      = r_wr;
    w_timeout_nxt = r_timeout;
    w_req         = 1'b0;
    w_stall       = 1'b0;
    w_retire      = 1'b0;
    w_md_sel      = MD_HOLD;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          w_req       = 1'b1;
          w_stall     = 1'b1;
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = 8'd0;
          // Latch direction so the completion cycle need not re-decode it.
          w_wr_nxt    = MEM_MemWrite;
        end else begin
          w_retire = 1'b1;
        end
      end
      S_WAIT: begin
        if (dmem_ready) begin
          w_retire    = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 8'd0;
          if (r_wr) begin
            w_md_sel = MD_HOLD;
          end else begin
            w_md_sel = MD_RDATA;
          end
        end else if (r_cnt >= C_LAST) begin
          // Abandon: retire the instruction with zero load data.
          w_retire      = 1'b1;
          w_state_nxt   = S_IDLE;
          w_cnt_nxt     = 8'd0;
          w_timeout_nxt = 1'b1;
          w_md_sel      = MD_ZERO;
        end else begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Access FSM, wait counter, latched direction and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_wr      <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wr      <= w_wr_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // MEM/WB pipeline register: retire the instruction or insert a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_regwrite <= 1'b0;
      r_wb_memtoreg <= 1'b0;
      r_wb_aluval   <= 16'h0000;
      r_wb_memdata  <= 16'h0000;
      r_wb_dstreg   <= 4'h0;
    end else if (w_retire) begin
      r_wb_regwrite <= MEM_RegWrite;
      r_wb_memtoreg <= MEM_MemtoReg;
      r_wb_aluval   <= MEM_ALUval;
      r_wb_dstreg   <= MEM_DstReg;
      case (w_md_sel)
        MD_RDATA: r_wb_memdata <= dmem_rdata;
        MD_ZERO:  r_wb_memdata <= 16'h0000;
        default:  r_wb_memdata <= r_wb_memdata;
      endcase
    end else begin
      // Bubble: kill the write-back controls, hold the data fields.
      r_wb_regwrite <= 1'b0;
      r_wb_memtoreg <= 1'b0;
    end
  end

  assign dmem_req    = w_req;
  assign dmem_wr     = MEM_MemWrite;
  assign dmem_addr   = MEM_ALUval;
  assign dmem_wdata  = MEM_ReadData2;
  assign mem_stall   = w_stall;
  assign mem_timeout = r_timeout;
  assign WB_RegWrite = r_wb_regwrite;
  assign WB_MemtoReg = r_wb_memtoreg;
  assign WB_ALUval   = r_wb_aluval;
  assign WB_MemData  = r_wb_memdata;
  assign WB_DstReg   = r_wb_dstreg;

endmodule
